// File: rtl/note_step_sequencer_pkg.sv
// Shared music definitions for the note step sequencer: MIDI field widths,
// the note-off velocity and the sequencer FSM state encoding.
package note_step_sequencer_pkg;

  localparam int NOTE_W = 8;
  localparam int VEL_W  = 8;

  localparam logic [VEL_W-1:0] NOTE_OFF_VELOCITY = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_SEND_ON  = 3'd3,
    ST_GATE     = 3'd4,
    ST_SEND_OFF = 3'd5,
    ST_REST     = 3'd6
  } seq_state_t;

endpackage

// File: rtl/note_step_sequencer_step_timer.sv
// Step period counter: restarts on each step start, counts while running and
// parks at the terminal count until the sequencer is ready for the next step.
module note_step_sequencer_step_timer
  import note_step_sequencer_pkg::*;
#(
  parameter int STEP_TICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic advance_ok,
  output logic at_term,
  output logic step_pulse
);

  localparam int SW = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
  localparam logic [SW-1:0] TERM = SW'(STEP_TICKS - 1);

  logic [SW-1:0] step_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt   <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= advance_ok;
      if (advance_ok) begin
        step_cnt <= '0;
      end else if (run && (step_cnt != TERM)) begin
        // Holding at TERM stretches the step while the consumer stalls.
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  assign at_term = (step_cnt == TERM);

endmodule

// File: rtl/note_step_sequencer.sv
// Tempo-driven step sequencer: walks the note ROM and emits a note-on /
// note-off event pair per step on a valid/ready stream.
module note_step_sequencer
  import note_step_sequencer_pkg::*;
#(
  parameter int N          = 3,
  parameter int STEP_TICKS = 16,
  parameter int GATE_TICKS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [N-1:0]      index,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [VEL_W-1:0]  rom_velocity,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_on,
  output logic [NOTE_W-1:0] evt_note,
  output logic [VEL_W-1:0]  evt_velocity,
  output logic              step_pulse,
  output logic              sounding
);

  localparam int GW = (GATE_TICKS > 2) ? $clog2(GATE_TICKS) : 1;
  // Leaving GATE on this count puts note-off valid exactly GATE_TICKS
  // cycles after the note-on handshake cycle.
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_TICKS - 2);

  seq_state_t    state;
  logic [GW-1:0] gate_cnt;
  logic          handshake;
  logic          run;
  logic          advance_ok;
  logic          at_term;

  assign handshake  = evt_valid & evt_ready;
  assign run        = (state != ST_IDLE);
  assign advance_ok = enable & ((state == ST_IDLE) | ((state == ST_REST) & at_term));

  note_step_sequencer_step_timer #(
    .STEP_TICKS(STEP_TICKS)
  ) u_step_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .advance_ok (advance_ok),
    .at_term    (at_term),
    .step_pulse (step_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      index        <= '0;
      gate_cnt     <= '0;
      evt_valid    <= 1'b0;
      evt_on       <= 1'b0;
      evt_note     <= '0;
      evt_velocity <= '0;
      sounding     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable) state <= ST_FETCH;
        end

        ST_FETCH: begin
          state <= enable ? ST_CAPTURE : ST_IDLE;
        end

        ST_CAPTURE: begin
          if (enable) begin
            evt_note     <= rom_note;
            evt_velocity <= rom_velocity;
            evt_on       <= 1'b1;
            evt_valid    <= 1'b1;
            state        <= ST_SEND_ON;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SEND_ON: begin
          // An accepted note-on always proceeds to its note-off, even if
          // enable drops in the same cycle.
          if (handshake) begin
            sounding <= 1'b1;
            gate_cnt <= '0;
            if (GATE_TICKS == 1) begin
              evt_on       <= 1'b0;
              evt_velocity <= NOTE_OFF_VELOCITY;
              evt_valid    <= 1'b1;
              state        <= ST_SEND_OFF;
            end else begin
              evt_valid <= 1'b0;
              state     <= ST_GATE;
            end
          end else if (!enable) begin
            evt_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          if (!enable || (gate_cnt == GATE_LAST)) begin
            evt_on       <= 1'b0;
            evt_velocity <= NOTE_OFF_VELOCITY;
            evt_valid    <= 1'b1;
            state        <= ST_SEND_OFF;
          end
        end

        ST_SEND_OFF: begin
          if (handshake) begin
            evt_valid <= 1'b0;
            sounding  <= 1'b0;
            index     <= index + 1'b1;
            state     <= ST_REST;
          end
        end

        ST_REST: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (at_term) begin
            state <= ST_FETCH;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
